// File: rtl/axis_usb_framer.sv
// axis_usb_framer: wraps an AXI-Stream sample stream into USB frames of
// header {A5A5, seq}, L payload words (zero pads on input timeout), and an
// XOR trailer, delivered through a single registered AXI-Stream output.
//
// Ports:
//   aclk, aresetn     clock, asynchronous active-low reset
//   cfg_len           payload words per frame (0 is treated as 1)
//   cfg_timeout       idle DATA cycles before padding starts (0 = never pad)
//   s_axis_*          sample input (tready is combinational)
//   m_axis_*          framed output towards the USB TX FIFO (registered)
//   sts_frames        completed frame count
//   sts_pads          inserted pad word count
module axis_usb_framer #(
  parameter int unsigned CNTR_WIDTH = 10
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CNTR_WIDTH-1:0] cfg_len,
  input  logic [15:0]           cfg_timeout,
  input  logic [31:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [31:0]           sts_frames,
  output logic [31:0]           sts_pads
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TMO_W   = 16;
  localparam logic [15:0] HDR_TAG = 16'hA5A5;
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  typedef enum logic [2:0] {IDLE, HEAD, DATA, PAD, TAIL} state_t;

  state_t                r_state,  w_state_nxt;
  logic [CNTR_WIDTH-1:0] r_len,    w_len_nxt;
  logic [CNTR_WIDTH-1:0] r_cnt,    w_cnt_nxt;
  logic [DATA_W-1:0]     r_xor,    w_xor_nxt;
  logic [TMO_W-1:0]      r_tmo,    w_tmo_nxt;
  logic [15:0]           r_seq,    w_seq_nxt;
  logic [DATA_W-1:0]     r_tdata,  w_tdata_nxt;
  logic                  r_tvalid, w_tvalid_nxt;
  logic [31:0]           r_frames, w_frames_nxt;
  logic [31:0]           r_pads,   w_pads_nxt;

  logic                  w_can_load;
  logic                  w_xfer;
  logic                  w_load;
  logic [DATA_W-1:0]     w_load_data;
  logic [CNTR_WIDTH-1:0] w_cnt_inc;
  logic [TMO_W-1:0]      w_tmo_inc;

  // Output register may take a new word when empty or being drained.
  assign w_can_load    = ~r_tvalid | m_axis_tready;
  assign s_axis_tready = (r_state == DATA) & w_can_load;
  assign w_xfer        = s_axis_tvalid & s_axis_tready;
  assign w_cnt_inc     = r_cnt + CNTR_WIDTH'(1);
  assign w_tmo_inc     = (r_tmo == TMO_MAX) ? r_tmo : r_tmo + TMO_W'(1);

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign sts_frames    = r_frames;
  assign sts_pads      = r_pads;

  // State register and datapath registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_cnt    <= '0;
      r_xor    <= '0;
      r_tmo    <= '0;
      r_seq    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_frames <= '0;
      r_pads   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_len    <= w_len_nxt;
      r_cnt    <= w_cnt_nxt;
      r_xor    <= w_xor_nxt;
      r_tmo    <= w_tmo_nxt;
      r_seq    <= w_seq_nxt;
      r_tdata  <= w_tdata_nxt;
      r_tvalid <= w_tvalid_nxt;
      r_frames <= w_frames_nxt;
      r_pads   <= w_pads_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt  = r_state;
    w_len_nxt    = r_len;
    w_cnt_nxt    = r_cnt;
    w_xor_nxt    = r_xor;
    w_tmo_nxt    = r_tmo;
    w_seq_nxt    = r_seq;
    w_frames_nxt = r_frames;
    w_pads_nxt   = r_pads;
    w_load       = 1'b0;
    w_load_data  = '0;

    case (r_state)
      IDLE: begin
        if (s_axis_tvalid) begin
          w_len_nxt   = (cfg_len == '0) ? CNTR_WIDTH'(1) : cfg_len;
          w_state_nxt = HEAD;
        end
      end
      HEAD: begin
        if (w_can_load) begin
          w_load      = 1'b1;
          w_load_data = {HDR_TAG, r_seq};
          w_cnt_nxt   = '0;
          w_xor_nxt   = '0;
          w_tmo_nxt   = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_xfer) begin
          // A transfer always beats a coincident timeout.
          w_load      = 1'b1;
          w_load_data = s_axis_tdata;
          w_xor_nxt   = r_xor ^ s_axis_tdata;
          w_cnt_nxt   = w_cnt_inc;
          w_tmo_nxt   = '0;
          if (w_cnt_inc == r_len) w_state_nxt = TAIL;
        end else if (!s_axis_tvalid) begin
          // Only true input starvation counts; back-pressure holds the count.
          w_tmo_nxt = w_tmo_inc;
          if ((cfg_timeout != '0) && (w_tmo_inc == cfg_timeout)) w_state_nxt = PAD;
        end
      end
      PAD: begin
        if (w_can_load) begin
          w_load      = 1'b1;
          w_load_data = '0;
          w_cnt_nxt   = w_cnt_inc;
          w_pads_nxt  = r_pads + 32'd1;
          if (w_cnt_inc == r_len) w_state_nxt = TAIL;
        end
      end
      TAIL: begin
        if (w_can_load) begin
          w_load       = 1'b1;
          w_load_data  = r_xor;
          w_frames_nxt = r_frames + 32'd1;
          w_seq_nxt    = r_seq + 16'd1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Output register: hold while stalled, otherwise take the new word or empty.
    w_tvalid_nxt = r_tvalid;
    w_tdata_nxt  = r_tdata;
    if (w_can_load) w_tvalid_nxt = w_load;
    if (w_load)     w_tdata_nxt  = w_load_data;
  end

endmodule

// File: tb/tb_axis_usb_framer.sv
// tb_axis_usb_framer: directed bench for axis_usb_framer. Expected output
// words are queued as stimulus is driven and compared as the DUT emits them.
module tb_axis_usb_framer;

  localparam int unsigned CW = 10;

  logic          aclk;
  logic          aresetn;
  logic [CW-1:0] cfg_len;
  logic [15:0]   cfg_timeout;
  logic [31:0]   s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [31:0]   sts_frames;
  logic [31:0]   sts_pads;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] tb_xor;
  logic [15:0] tb_seq;
  bit          bp_en;
  bit          stall_pend;
  logic [31:0] stall_data;

  axis_usb_framer #(.CNTR_WIDTH(CW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_len       (cfg_len),
    .cfg_timeout   (cfg_timeout),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .sts_frames    (sts_frames),
    .sts_pads      (sts_pads)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Downstream ready: always 1, or toggling each cycle when bp_en is set.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (bp_en) m_axis_tready = ~m_axis_tready;
      else       m_axis_tready = 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on each handshake, checks stall stability.
  initial begin
    stall_pend = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stall_pend = 1'b0;
      end else begin
        if (stall_pend) begin
          chk("stall_valid", 32'(m_axis_tvalid), 32'd1);
          chk("stall_data", m_axis_tdata, stall_data);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL extra_word observed=%08h expected=none", m_axis_tdata);
          end else begin
            chk("m_word", m_axis_tdata, exp_q.pop_front());
          end
          stall_pend = 1'b0;
        end else if (m_axis_tvalid) begin
          stall_pend = 1'b1;
          stall_data = m_axis_tdata;
        end else begin
          stall_pend = 1'b0;
        end
      end
    end
  end

  task automatic begin_frame();
    exp_q.push_back({16'hA5A5, tb_seq});
    tb_xor = '0;
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input logic [31:0] d);
    bit acc;
    acc = 1'b0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge aclk);
      if (s_axis_tready) acc = 1'b1;
      @(posedge aclk);
      #1;
    end
    if (acc) begin
      exp_q.push_back(d);
      tb_xor = tb_xor ^ d;
    end
    checks++;
    assert (acc) else begin
      failures++;
      $error("FAIL send_accept observed=0 expected=1 data=%08h", d);
    end
  endtask

  task automatic end_frame(input int pads);
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < pads; i++) exp_q.push_back(32'h0);
    exp_q.push_back(tb_xor);
    tb_seq = tb_seq + 16'd1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge aclk);
      n++;
    end
    @(posedge aclk);
    #1;
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL %s observed=%0d_pending expected=0_pending", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    bp_en         = 1'b0;
    tb_seq        = '0;
    tb_xor        = '0;
    aresetn       = 1'b0;
    cfg_len       = CW'(4);
    cfg_timeout   = 16'd0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_m_tdata", m_axis_tdata, 32'd0);
    chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_frames", sts_frames, 32'd0);
    chk("rst_pads", sts_pads, 32'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Basic frame; cfg_len change mid-frame must be ignored.
    cfg_len = CW'(4);
    begin_frame();
    send(32'd1);
    cfg_len = CW'(7);
    send(32'd2);
    send(32'd3);
    send(32'd4);
    end_frame(0);
    wait_drain("basic");
    chk("basic_trailer_model", tb_xor, 32'h4);
    chk("basic_frames", sts_frames, 32'd1);
    chk("basic_pads", sts_pads, 32'd0);

    // Timeout padding after two samples.
    cfg_len     = CW'(4);
    cfg_timeout = 16'd8;
    begin_frame();
    send(32'd5);
    send(32'd6);
    end_frame(2);
    wait_drain("timeout");
    chk("timeout_frames", sts_frames, 32'd2);
    chk("timeout_pads", sts_pads, 32'd2);

    // Back-pressure: ready toggling, no padding expected.
    cfg_len     = CW'(16);
    cfg_timeout = 16'd4;
    bp_en       = 1'b1;
    begin_frame();
    for (int i = 0; i < 16; i++) send($urandom());
    end_frame(0);
    wait_drain("backpressure");
    bp_en = 1'b0;
    @(posedge aclk);
    #1;
    chk("bp_frames", sts_frames, 32'd3);
    chk("bp_pads", sts_pads, 32'd2);

    // Length zero means one payload word.
    cfg_len     = CW'(0);
    cfg_timeout = 16'd0;
    begin_frame();
    send(32'hDEADBEEF);
    end_frame(0);
    wait_drain("len0");
    chk("len0_frames", sts_frames, 32'd4);

    // Reset mid-frame after two of four payload words.
    cfg_len = CW'(4);
    begin_frame();
    send(32'h11);
    send(32'h22);
    s_axis_tvalid = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    chk("pre_rst_pending", 32'(exp_q.size()), 32'd0);
    aresetn = 1'b0;
    #1;
    chk("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midrst_s_tready", 32'(s_axis_tready), 32'd0);
    chk("midrst_frames", sts_frames, 32'd0);
    chk("midrst_pads", sts_pads, 32'd0);
    exp_q.delete();
    tb_seq = '0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    begin_frame();
    send(32'hA);
    send(32'hB);
    send(32'hC);
    send(32'hD);
    end_frame(0);
    wait_drain("post_rst");
    chk("post_rst_frames", sts_frames, 32'd1);

    // Sequence wrap: preload seq to FFFF while idle.
    @(negedge aclk);
    force dut.r_seq = 16'hFFFF;
    @(negedge aclk);
    release dut.r_seq;
    tb_seq  = 16'hFFFF;
    cfg_len = CW'(1);
    @(posedge aclk);
    #1;
    begin_frame();
    send(32'h12345678);
    end_frame(0);
    wait_drain("wrap_ffff");
    begin_frame();
    send(32'h9ABCDEF0);
    end_frame(0);
    wait_drain("wrap_0000");
    chk("wrap_seq_model", 32'(tb_seq), 32'd1);
    chk("wrap_frames", sts_frames, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_usb_framer.md
AXIS_USB_FRAMER -- requirements
Module: axis_usb_framer

Interface
REQ-001 SHALL have parameter CNTR_WIDTH, default 10, giving the width of the payload length and word counters.
REQ-002 SHALL have port aclk, input, 1, the single clock for all logic.
REQ-003 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cfg_len, input, CNTR_WIDTH, payload words per frame.
REQ-005 SHALL have port cfg_timeout, input, 16, idle cycles before padding starts; 0 disables padding.
REQ-006 SHALL have port s_axis_tdata, input, 32, sample word.
REQ-007 SHALL have port s_axis_tvalid, input, 1, sample valid.
REQ-008 SHALL have port s_axis_tready, output, 1, sample accepted.
REQ-009 SHALL have port m_axis_tdata, output, 32, framed word sent to the USB TX FIFO.
REQ-010 SHALL have port m_axis_tvalid, output, 1, framed word valid.
REQ-011 SHALL have port m_axis_tready, input, 1, downstream ready; driven from TX FIFO not-full.
REQ-012 SHALL have port sts_frames, output, 32, count of completed frames.
REQ-013 SHALL have port sts_pads, output, 32, count of inserted pad words.

Function
REQ-014 SHALL emit each frame as one header word, then L payload words, then one trailer word, in that order with no interleaving.
REQ-015 SHALL set L = cfg_len, except that cfg_len = 0 gives L = 1; L is sampled once in IDLE at frame start and held for the whole frame.
REQ-016 SHALL set the header to {16'hA5A5, seq[15:0]}; seq resets to 0, increments after each trailer and wraps from 0xFFFF to 0x0000.
REQ-017 SHALL set the trailer to the 32-bit XOR of all accepted sample words in the frame; pad words contribute 0.
REQ-018 SHALL drive m_axis from a single output register.
  - Register loads when ~m_axis_tvalid | m_axis_tready.
  - tdata and tvalid stay stable while tvalid & ~tready.
REQ-019 SHALL assert s_axis_tready only in state DATA while the output register can load; s_axis_tready is combinational from state and m_axis_tready.
REQ-020 SHALL use FSM states IDLE, HEAD, DATA, PAD, TAIL.
REQ-021 IDLE: on s_axis_tvalid, latch L and go to HEAD; no sample is consumed in IDLE.
REQ-022 HEAD: load the header when the output register can load, clear the word counter and XOR accumulator, go to DATA.
REQ-023 DATA: each transfer (tvalid & tready) loads the sample, XORs it into the accumulator, increments the counter and clears the timeout counter.
REQ-024 DATA: when the counter reaches L, go to TAIL.
REQ-025 DATA: each cycle with ~s_axis_tvalid increments the timeout counter; when it equals a nonzero cfg_timeout, go to PAD.
REQ-026 DATA: if a transfer and the timeout fall in the same cycle, the transfer wins and the timeout counter clears.
REQ-027 PAD: load 32'h0 each time the output register can load, increment the word counter and sts_pads; at counter = L go to TAIL.
REQ-028 PAD: samples are refused (s_axis_tready = 0) for the rest of the frame.
REQ-029 TAIL: load the trailer when the output register can load, increment sts_frames and seq, go to IDLE.
REQ-030 SHALL hold the timeout counter while m_axis back-pressure blocks a transfer with s_axis_tvalid high.
REQ-031 SHALL saturate the timeout counter at 0xFFFF.
REQ-032 SHALL let sts_frames and sts_pads wrap modulo 2^32.
REQ-033 SHALL ignore changes to cfg_len mid-frame.
REQ-034 SHALL apply changes to cfg_timeout from the next cycle.

Reset
REQ-035 SHALL, while aresetn = 0, drive m_axis_tvalid = 0, m_axis_tdata = 0, s_axis_tready = 0, sts_frames = 0, sts_pads = 0, seq = 0, state = IDLE, and clear all counters.
REQ-036 SHALL, when reset is asserted mid-frame, abandon the partial frame with no trailer; the first frame after release carries seq 0.

Verification
REQ-037 SHALL cover a basic frame: cfg_len = 4, m_axis_tready = 1, samples 1,2,3,4 -> output A5A50000, 1, 2, 3, 4, 00000004; sts_frames = 1.
REQ-038 SHALL cover timeout padding: cfg_len = 4, cfg_timeout = 8, samples 5 and 6, then tvalid low -> after 8 idle cycles output 0, 0, then trailer 00000003; sts_pads = 2.
REQ-039 SHALL cover back-pressure: m_axis_tready toggled every cycle during a cfg_len = 16 frame -> no lost or duplicated words, tdata stable while stalled, trailer correct, no padding with cfg_timeout = 4.
REQ-040 SHALL cover length zero: cfg_len = 0 -> frame of header, one sample, trailer (3 words).
REQ-041 SHALL cover sequence wrap: preload by running 65537 frames, or force seq = FFFF -> headers A5A5FFFF then A5A50000.
REQ-042 SHALL cover reset mid-frame: aresetn low after 2 of 4 payload words -> m_axis_tvalid = 0 at once; the next frame header is A5A50000 and sts_frames = 0.
